proc_fetch: RTL and testbench

- Instruction sequencer that sits directly upstream of the 9-bit multi-cycle processor.
- Holds a small loadable program memory and a program counter.
- Drives the processor's DIN and Run inputs and consumes its Done output.
- Issues one instruction at a time, supplies the immediate word for mvi, and advances the PC. Supports free-run and single-step execution.

---
 rtl/proc_fetch.sv | 173 +++++++++++++++++
 tb/tb_proc_fetch.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_fetch.sv
// Instruction sequencer feeding the 9-bit multi-cycle processor: loadable program memory, PC, Run/Done handshake.
// Optional watchdog FAULT state enabled by defining PROC_FETCH_WATCHDOG_EN.
module proc_fetch #(
    parameter int          ADDR_W  = 5,
    parameter int          DEPTH   = 32,
    parameter logic [2:0]  HALT_OP = 3'b111
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              LoadEn,
    input  logic [ADDR_W-1:0] LoadAddr,
    input  logic [8:0]        LoadData,
    input  logic              Start,
    input  logic              StepMode,
    input  logic              Done,
    output logic [8:0]        DIN,
    output logic              Run,
    output logic [ADDR_W-1:0] PC,
    output logic              Busy,
    output logic              Halted,
    output logic [7:0]        InstrCount,
    output logic              Fault,
    output logic [2:0]        dbg_state_o
);

    localparam logic [2:0] OP_MVI = 3'b001;

`ifdef PROC_FETCH_WATCHDOG_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_HALTED = 3'd3,
        S_FAULT  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_HALTED = 3'd3
    } state_t;
`endif

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              run_q;
    logic              busy_q;
    logic              halted_q;
    logic              mvi_q;
    logic [7:0]        cnt_q;
    logic [8:0]        mem_q [DEPTH];

    logic [ADDR_W-1:0] pc_inc_d;
    logic [ADDR_W-1:0] pc_wait_d;
    logic [2:0]        op_cur;
    logic [2:0]        op_wait;

    assign DIN       = mem_q[pc_q];
    assign op_cur    = mem_q[pc_q][7:5];
    assign pc_inc_d  = pc_q + ADDR_W'(1);
    // An mvi consumed its immediate word, so completion skips past it.
    assign pc_wait_d = mvi_q ? pc_inc_d : pc_q;
    assign op_wait   = mem_q[pc_wait_d][7:5];

    // Program loading is only accepted while nothing is executing.
    always_ff @(posedge Clock) begin
        if (LoadEn && (state_q == S_IDLE || state_q == S_HALTED)) begin
            mem_q[LoadAddr] <= LoadData;
        end
    end

`ifdef PROC_FETCH_WATCHDOG_EN
    logic [2:0] wd_q;
    logic       fault_q;
    assign Fault = fault_q;
`else
    assign Fault = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            run_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            mvi_q    <= 1'b0;
            cnt_q    <= 8'd0;
`ifdef PROC_FETCH_WATCHDOG_EN
            wd_q     <= 3'd0;
            fault_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        if (op_cur == HALT_OP) begin
                            state_q  <= S_HALTED;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= S_ISSUE;
                            run_q   <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    pc_q    <= pc_inc_d;
                    mvi_q   <= (op_cur == OP_MVI);
                    state_q <= S_WAIT;
                    run_q   <= 1'b0;
`ifdef PROC_FETCH_WATCHDOG_EN
                    wd_q    <= 3'd0;
`endif
                end
                S_WAIT: begin
                    if (Done) begin
                        pc_q  <= pc_wait_d;
                        cnt_q <= cnt_q + 8'd1;
                        if (op_wait == HALT_OP) begin
                            state_q  <= S_HALTED;
                            busy_q   <= 1'b0;
                            halted_q <= 1'b1;
                        end else if (StepMode) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_ISSUE;
                            run_q   <= 1'b1;
                        end
                    end
`ifdef PROC_FETCH_WATCHDOG_EN
                    // Seventh silent WAIT cycle: give up on the processor.
                    else if (wd_q == 3'd6) begin
                        wd_q    <= 3'd7;
                        state_q <= S_FAULT;
                        busy_q  <= 1'b0;
                        fault_q <= 1'b1;
                    end else begin
                        wd_q <= wd_q + 3'd1;
                    end
`endif
                end
                S_HALTED: begin
                    if (Start) begin
                        pc_q     <= '0;
                        state_q  <= S_IDLE;
                        halted_q <= 1'b0;
                    end
                end
`ifdef PROC_FETCH_WATCHDOG_EN
                S_FAULT: begin
                    state_q <= S_FAULT;
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                    run_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Run         = run_q;
    assign PC          = pc_q;
    assign Busy        = busy_q;
    assign Halted      = halted_q;
    assign InstrCount  = cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_proc_fetch.sv
// Directed bench for proc_fetch: the processor's Done is driven by hand from the test tasks.
module tb_proc_fetch;

    localparam logic [8:0] W_MV   = 9'h001;
    localparam logic [8:0] W_MVI  = 9'h020;
    localparam logic [8:0] W_ADD  = 9'h042;
    localparam logic [8:0] W_SUB  = 9'h063;
    localparam logic [8:0] W_HALT = 9'h0E0;

    logic       Clock;
    logic       Resetn;
    logic       LoadEn;
    logic [4:0] LoadAddr;
    logic [8:0] LoadData;
    logic       Start;
    logic       StepMode;
    logic       Done;
    logic [8:0] DIN;
    logic       Run;
    logic [4:0] PC;
    logic       Busy;
    logic       Halted;
    logic [7:0] InstrCount;
    logic       Fault;
    logic [2:0] dbg_state;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic exp_q[$];

    proc_fetch dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .LoadEn      (LoadEn),
        .LoadAddr    (LoadAddr),
        .LoadData    (LoadData),
        .Start       (Start),
        .StepMode    (StepMode),
        .Done        (Done),
        .DIN         (DIN),
        .Run         (Run),
        .PC          (PC),
        .Busy        (Busy),
        .Halted      (Halted),
        .InstrCount  (InstrCount),
        .Fault       (Fault),
        .dbg_state_o (dbg_state)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic do_reset();
        Resetn   = 1'b0;
        LoadEn   = 1'b0;
        LoadAddr = '0;
        LoadData = '0;
        Start    = 1'b0;
        StepMode = 1'b0;
        Done     = 1'b0;
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);
    endtask

    task automatic load_word(input logic [4:0] addr, input logic [8:0] data);
        LoadEn   = 1'b1;
        LoadAddr = addr;
        LoadData = data;
        @(negedge Clock);
        LoadEn = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt += 6;
        if (PC !== 5'd0) $display("FAIL reset_pc got=%0d exp=0", PC); else pass_cnt++;
        if (Run !== 1'b0) $display("FAIL reset_run got=%b exp=0", Run); else pass_cnt++;
        if (InstrCount !== 8'd0) $display("FAIL reset_count got=%0d exp=0", InstrCount); else pass_cnt++;
        if (Busy !== 1'b0 || Halted !== 1'b0) $display("FAIL reset_busy_halted got=%b%b exp=00", Busy, Halted); else pass_cnt++;
        if (Fault !== 1'b0) $display("FAIL reset_fault got=%b exp=0", Fault); else pass_cnt++;
        if (dbg_state !== 3'd0) $display("FAIL reset_state got=%0d exp=0", dbg_state); else pass_cnt++;
    endtask

    task automatic test_mvi();
        do_reset();
        load_word(5'd0, W_MVI);
        load_word(5'd1, 9'd5);
        load_word(5'd2, W_HALT);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        total_cnt += 3;
        if (Run !== 1'b1) $display("FAIL mvi_issue_run got=%b exp=1", Run); else pass_cnt++;
        if (PC !== 5'd0) $display("FAIL mvi_issue_pc got=%0d exp=0", PC); else pass_cnt++;
        if (DIN !== W_MVI) $display("FAIL mvi_issue_din got=%h exp=%h", DIN, W_MVI); else pass_cnt++;
        @(negedge Clock);
        total_cnt += 3;
        if (Run !== 1'b0) $display("FAIL mvi_wait_run got=%b exp=0", Run); else pass_cnt++;
        if (DIN !== 9'd5) $display("FAIL mvi_wait_imm got=%h exp=005", DIN); else pass_cnt++;
        if (Busy !== 1'b1 || PC !== 5'd1) $display("FAIL mvi_wait_busy_pc got=%b/%0d exp=1/1", Busy, PC); else pass_cnt++;
        Done = 1'b1;
        @(negedge Clock);
        Done = 1'b0;
        total_cnt += 3;
        if (Halted !== 1'b1 || Busy !== 1'b0) $display("FAIL mvi_halted got=%b%b exp=10", Halted, Busy); else pass_cnt++;
        if (PC !== 5'd2) $display("FAIL mvi_final_pc got=%0d exp=2", PC); else pass_cnt++;
        if (InstrCount !== 8'd1) $display("FAIL mvi_count got=%0d exp=1", InstrCount); else pass_cnt++;
    endtask

    task automatic test_free_run();
        do_reset();
        load_word(5'd0, W_MV);
        load_word(5'd1, W_ADD);
        load_word(5'd2, W_SUB);
        load_word(5'd3, W_HALT);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (Run !== 1'b1 || PC !== 5'(i)) $display("FAIL free_issue_%0d got run=%b pc=%0d exp run=1 pc=%0d", i, Run, PC, i); else pass_cnt++;
            @(negedge Clock);
            // Instruction i takes i extra WAIT cycles before Done.
            for (int k = 0; k <= i; k++) begin
                total_cnt++;
                if (Run !== 1'b0 || Busy !== 1'b1) $display("FAIL free_wait_%0d got run=%b busy=%b exp run=0 busy=1", i, Run, Busy); else pass_cnt++;
                if (k < i) @(negedge Clock);
            end
            Done = 1'b1;
            @(negedge Clock);
            Done = 1'b0;
        end
        total_cnt += 3;
        if (Halted !== 1'b1 || Run !== 1'b0) $display("FAIL free_halted got=%b run=%b exp=1 run=0", Halted, Run); else pass_cnt++;
        if (PC !== 5'd3) $display("FAIL free_pc got=%0d exp=3", PC); else pass_cnt++;
        if (InstrCount !== 8'd3) $display("FAIL free_count got=%0d exp=3", InstrCount); else pass_cnt++;
    endtask

    task automatic test_step();
        do_reset();
        load_word(5'd0, W_MV);
        load_word(5'd1, W_ADD);
        load_word(5'd2, W_SUB);
        load_word(5'd3, W_HALT);
        StepMode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            Start = 1'b1;
            @(negedge Clock);
            Start = 1'b0;
            total_cnt++;
            if (Run !== 1'b1 || PC !== 5'(i)) $display("FAIL step_issue_%0d got run=%b pc=%0d exp run=1 pc=%0d", i, Run, PC, i); else pass_cnt++;
            @(negedge Clock);
            Done = 1'b1;
            @(negedge Clock);
            Done = 1'b0;
            if (i < 2) begin
                total_cnt++;
                if (Busy !== 1'b0 || Run !== 1'b0 || PC !== 5'(i + 1)) $display("FAIL step_idle_%0d got busy=%b run=%b pc=%0d exp 0 0 %0d", i, Busy, Run, PC, i + 1); else pass_cnt++;
                @(negedge Clock);
                total_cnt++;
                if (Busy !== 1'b0 || Run !== 1'b0) $display("FAIL step_hold_%0d got busy=%b run=%b exp 0 0", i, Busy, Run); else pass_cnt++;
            end
        end
        StepMode = 1'b0;
        total_cnt += 2;
        if (Halted !== 1'b1 || PC !== 5'd3) $display("FAIL step_halt got=%b pc=%0d exp=1 pc=3", Halted, PC); else pass_cnt++;
        if (InstrCount !== 8'd3) $display("FAIL step_count got=%0d exp=3", InstrCount); else pass_cnt++;
    endtask

    task automatic test_load_busy();
        do_reset();
        for (int a = 0; a < 4; a++) load_word(5'(a), W_ADD);
        load_word(5'd4, W_HALT);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        LoadEn   = 1'b1;
        LoadAddr = 5'd4;
        LoadData = W_ADD;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (Busy !== 1'b1) $display("FAIL load_busy_%0d got=%b exp=1", i, Busy); else pass_cnt++;
            @(negedge Clock);
            Done = 1'b1;
            @(negedge Clock);
            Done = 1'b0;
        end
        LoadEn = 1'b0;
        total_cnt += 2;
        if (Halted !== 1'b1 || PC !== 5'd4) $display("FAIL load_halt got=%b pc=%0d exp=1 pc=4", Halted, PC); else pass_cnt++;
        if (DIN !== W_HALT) $display("FAIL load_readback got=%h exp=%h", DIN, W_HALT); else pass_cnt++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int a = 0; a < 31; a++) load_word(5'(a), W_ADD);
        load_word(5'd31, W_MVI);
        StepMode = 1'b1;
        for (int i = 0; i < 31; i++) begin
            Start = 1'b1;
            @(negedge Clock);
            Start = 1'b0;
            @(negedge Clock);
            Done = 1'b1;
            @(negedge Clock);
            Done = 1'b0;
            total_cnt++;
            if (PC !== 5'(i + 1) || Busy !== 1'b0) $display("FAIL wrap_step_%0d got pc=%0d busy=%b exp pc=%0d busy=0", i, PC, Busy, i + 1); else pass_cnt++;
        end
        load_word(5'd0, 9'h1AB);
        load_word(5'd1, W_HALT);
        StepMode = 1'b0;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        total_cnt++;
        if (Run !== 1'b1 || PC !== 5'd31 || DIN !== W_MVI) $display("FAIL wrap_issue got run=%b pc=%0d din=%h exp 1 31 %h", Run, PC, DIN, W_MVI); else pass_cnt++;
        @(negedge Clock);
        total_cnt++;
        if (PC !== 5'd0 || DIN !== 9'h1AB) $display("FAIL wrap_imm got pc=%0d din=%h exp pc=0 din=1ab", PC, DIN); else pass_cnt++;
        Done = 1'b1;
        @(negedge Clock);
        Done = 1'b0;
        total_cnt += 2;
        if (Halted !== 1'b1 || PC !== 5'd1) $display("FAIL wrap_final got halted=%b pc=%0d exp 1 1", Halted, PC); else pass_cnt++;
        if (InstrCount !== 8'd32) $display("FAIL wrap_count got=%0d exp=32", InstrCount); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        load_word(5'd0, W_ADD);
        load_word(5'd1, W_ADD);
        load_word(5'd2, W_HALT);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        @(negedge Clock);
        Done = 1'b1;
        @(negedge Clock);
        Done = 1'b0;
        @(negedge Clock);
        total_cnt++;
        if (Busy !== 1'b1 || PC !== 5'd2 || InstrCount !== 8'd1) $display("FAIL mid_before got busy=%b pc=%0d cnt=%0d exp 1 2 1", Busy, PC, InstrCount); else pass_cnt++;
        #2;
        Resetn = 1'b0;
        #1;
        total_cnt += 2;
        if (Run !== 1'b0 || Busy !== 1'b0) $display("FAIL mid_async_run got run=%b busy=%b exp 0 0", Run, Busy); else pass_cnt++;
        if (PC !== 5'd0 || InstrCount !== 8'd0) $display("FAIL mid_async_pc got pc=%0d cnt=%0d exp 0 0", PC, InstrCount); else pass_cnt++;
        @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);
        total_cnt++;
        if (Busy !== 1'b0 || Halted !== 1'b0 || dbg_state !== 3'd0) $display("FAIL mid_idle got busy=%b halted=%b st=%0d exp 0 0 0", Busy, Halted, dbg_state); else pass_cnt++;
    endtask

    task automatic test_step_cadence();
        logic exp;
        do_reset();
        load_word(5'd0, W_MV);
        load_word(5'd1, W_MV);
        load_word(5'd2, W_MV);
        load_word(5'd3, W_HALT);
        for (int i = 0; i < 9; i++) exp_q.push_back(i % 3 == 0);
        StepMode = 1'b1;
        Done     = 1'b1;
        Start    = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge Clock);
            exp = exp_q.pop_front();
            total_cnt++;
            if (Run !== exp) $display("FAIL cadence_%0d got run=%b exp=%b", i, Run, exp); else pass_cnt++;
        end
        Start    = 1'b0;
        Done     = 1'b0;
        StepMode = 1'b0;
        total_cnt++;
        if (Halted !== 1'b1 || PC !== 5'd3 || InstrCount !== 8'd3) $display("FAIL cadence_end got halted=%b pc=%0d cnt=%0d exp 1 3 3", Halted, PC, InstrCount); else pass_cnt++;
    endtask

    task automatic test_watchdog();
        do_reset();
        load_word(5'd0, W_ADD);
        load_word(5'd1, W_HALT);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        @(negedge Clock);
`ifdef PROC_FETCH_WATCHDOG_EN
        repeat (6) @(negedge Clock);
        total_cnt++;
        if (Fault !== 1'b0 || Busy !== 1'b1) $display("FAIL wd_early got fault=%b busy=%b exp 0 1", Fault, Busy); else pass_cnt++;
        @(negedge Clock);
        total_cnt++;
        if (Fault !== 1'b1 || Run !== 1'b0 || PC !== 5'd1) $display("FAIL wd_fault got fault=%b run=%b pc=%0d exp 1 0 1", Fault, Run, PC); else pass_cnt++;
        Done  = 1'b1;
        Start = 1'b1;
        repeat (3) @(negedge Clock);
        Done  = 1'b0;
        Start = 1'b0;
        total_cnt++;
        if (Fault !== 1'b1 || PC !== 5'd1 || Run !== 1'b0) $display("FAIL wd_sticky got fault=%b pc=%0d run=%b exp 1 1 0", Fault, PC, Run); else pass_cnt++;
`else
        repeat (10) @(negedge Clock);
        total_cnt++;
        if (Fault !== 1'b0 || Busy !== 1'b1 || PC !== 5'd1) $display("FAIL nowd_wait got fault=%b busy=%b pc=%0d exp 0 1 1", Fault, Busy, PC); else pass_cnt++;
        Done = 1'b1;
        @(negedge Clock);
        Done = 1'b0;
        total_cnt++;
        if (Halted !== 1'b1 || InstrCount !== 8'd1) $display("FAIL nowd_done got halted=%b cnt=%0d exp 1 1", Halted, InstrCount); else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_mvi();
        test_free_run();
        test_step();
        test_load_busy();
        test_wrap();
        test_reset_mid();
        test_step_cadence();
        test_watchdog();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
